// File: rtl/axi_tg_pkg.sv
// Shared definitions for the frame write path: scheduler state encoding,
// AXI write-response codes and the burst size derivation used by the
// scheduler, the burst engine and the frame generator.
package axi_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_RESP = 3'd2,
        ST_FRAME_END = 3'd3,
        ST_HOLD      = 3'd4
    } sched_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Bytes moved by one burst of (burst_len+1) beats of data_w bits.
    function automatic int unsigned burst_bytes(input int unsigned burst_len,
                                                input int unsigned data_w);
        return (burst_len + 1) * data_w / 8;
    endfunction

endpackage

// File: rtl/frame_wr_scheduler.sv
// Frame write scheduler: walks the active frame buffer one fixed-length
// burst at a time, counts failed write responses, pulses an interrupt at
// frame end and swaps buffers once the display side has released the other.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | scheduler stopped; offset held at 0
// ISSUE      | request the burst at base(wr_buf)+offset when engine is free
// WAIT_RESP  | one burst outstanding, waiting for its write response
// FRAME_END  | one cycle: irq, frame count, swap if buffer already released
// HOLD       | frame done, waiting for the display to release the buffer
module frame_wr_scheduler
    import axi_tg_pkg::*;
#(
    parameter int unsigned         ADDR_W      = 32,
    parameter int unsigned         DATA_W      = 64,
    parameter int unsigned         BURST_LEN   = 15,
    parameter logic [ADDR_W-1:0]   BUF0_BASE   = 32'h10000000,
    parameter logic [ADDR_W-1:0]   BUF1_BASE   = 32'h10800000,
    parameter int unsigned         FRAME_BYTES = 8294400
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              enable,
    input  logic              eng_free,
    output logic              eng_start,
    output logic [ADDR_W-1:0] eng_addr,
    output logic [3:0]        eng_len,
    input  logic              eng_resp_valid,
    input  logic [1:0]        eng_resp,
    input  logic              buf_release,
    output logic              wr_buf,
    output logic [3:0]        frame_cnt,
    output logic              frame_irq,
    output logic [15:0]       err_cnt,
    output logic              busy
);

    localparam int unsigned       BURST_BYTES = burst_bytes(BURST_LEN, DATA_W);
    localparam logic [ADDR_W-1:0] BURST_STEP  = ADDR_W'(BURST_BYTES);
    localparam logic [ADDR_W-1:0] LAST_OFFSET = ADDR_W'(FRAME_BYTES - BURST_BYTES);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [ADDR_W-1:0] offset;
    logic [15:0]       err_cnt_q;
    logic              rel_flag;
    logic              swap_buf;
    logic              resp_is_err;
    logic              last_burst;

    // EXOKAY is a successful completion; only SLVERR and DECERR count.
    assign resp_is_err = (eng_resp == AXI_RESP_SLVERR) || (eng_resp == AXI_RESP_DECERR);
    assign last_burst  = (offset == LAST_OFFSET);

    assign eng_len = 4'(BURST_LEN);
    assign err_cnt = err_cnt_q;
    assign busy    = (state != ST_IDLE);
    // Address is only meaningful alongside eng_start; drive 0 otherwise.
    assign eng_addr = eng_start ? ((wr_buf ? BUF1_BASE : BUF0_BASE) + offset) : '0;

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt = state;
        eng_start = 1'b0;
        frame_irq = 1'b0;
        swap_buf  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                eng_start = eng_free;
                if (eng_free) state_nxt = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (eng_resp_valid) begin
                    if (last_burst)  state_nxt = ST_FRAME_END;
                    else if (enable) state_nxt = ST_ISSUE;
                    else             state_nxt = ST_IDLE;
                end
            end
            ST_FRAME_END: begin
                frame_irq = 1'b1;
                if (rel_flag || buf_release) begin
                    swap_buf  = 1'b1;
                    state_nxt = enable ? ST_ISSUE : ST_IDLE;
                end else begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (buf_release) begin
                    swap_buf  = 1'b1;
                    state_nxt = enable ? ST_ISSUE : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Burst offset, frame/error counters, buffer select and release flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            offset    <= '0;
            err_cnt_q <= '0;
            frame_cnt <= '0;
            wr_buf    <= 1'b0;
            rel_flag  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    offset <= '0;
                end
                ST_WAIT_RESP: begin
                    if (eng_resp_valid) begin
                        if (resp_is_err && (err_cnt_q != 16'hFFFF)) begin
                            err_cnt_q <= err_cnt_q + 16'd1;
                        end
                        if (!last_burst) begin
                            offset <= offset + BURST_STEP;
                        end
                    end
                end
                ST_FRAME_END: begin
                    offset    <= '0;
                    frame_cnt <= frame_cnt + 4'd1;
                end
                default: ;
            endcase

            // A release during FRAME_END/HOLD is consumed by the swap itself.
            if (swap_buf) begin
                wr_buf   <= ~wr_buf;
                rel_flag <= 1'b0;
            end else if (buf_release && (state != ST_FRAME_END) && (state != ST_HOLD)) begin
                rel_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_wr_scheduler.sv
// Directed/randomized bench for frame_wr_scheduler with a small frame
// (4 bursts of 128 bytes) and a buffer/burst-index reference model.
module tb_frame_wr_scheduler;

    localparam logic [31:0] B0 = 32'h10000000;
    localparam logic [31:0] B1 = 32'h10800000;
    localparam int BB = (15 + 1) * 64 / 8;
    localparam int FB = 512;
    localparam int NB = FB / BB;

    logic        aclk = 1'b0;
    logic        areset;
    logic        enable;
    logic        eng_free;
    logic        eng_start;
    logic [31:0] eng_addr;
    logic [3:0]  eng_len;
    logic        eng_resp_valid;
    logic [1:0]  eng_resp;
    logic        buf_release;
    logic        wr_buf;
    logic [3:0]  frame_cnt;
    logic        frame_irq;
    logic [15:0] err_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic        exp_buf = 1'b0;
    int          exp_idx = 0;
    int          exp_fc  = 0;
    logic [15:0] exp_err = 16'd0;
    logic        exp_rel = 1'b1;

    frame_wr_scheduler #(.FRAME_BYTES(FB)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .enable         (enable),
        .eng_free       (eng_free),
        .eng_start      (eng_start),
        .eng_addr       (eng_addr),
        .eng_len        (eng_len),
        .eng_resp_valid (eng_resp_valid),
        .eng_resp       (eng_resp),
        .buf_release    (buf_release),
        .wr_buf         (wr_buf),
        .frame_cnt      (frame_cnt),
        .frame_irq      (frame_irq),
        .err_cnt        (err_cnt),
        .busy           (busy)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    // One burst from ISSUE: optional engine stall, response after dly
    // waiting cycles, rel_pulses buf_release pulses while waiting.
    task automatic issue_burst(input int stall, input int dly, input logic [1:0] rc,
                               input logic en_at_resp, input int rel_pulses);
        logic [31:0] ea;
        logic        last;
        ea = (exp_buf ? B1 : B0) + 32'(exp_idx * BB);
        for (int i = 0; i < stall; i++) begin
            eng_free = 1'b0;
            #1;
            chk("stall_start", 32'(eng_start), 0);
            chk("stall_busy", 32'(busy), 1);
            step();
        end
        eng_free = 1'b1;
        #1;
        chk("start", 32'(eng_start), 1);
        chk("addr", eng_addr, ea);
        chk("len", 32'(eng_len), 15);
        chk("irq_mid", 32'(frame_irq), 0);
        step();
        for (int i = 0; i < dly; i++) begin
            buf_release = ((i % 2) == 0) && ((i / 2) < rel_pulses);
            if (buf_release) exp_rel = 1'b1;
            #1;
            chk("wait_start", 32'(eng_start), 0);
            step();
        end
        buf_release    = 1'b0;
        enable         = en_at_resp;
        eng_resp_valid = 1'b1;
        eng_resp       = rc;
        #1;
        chk("resp_start", 32'(eng_start), 0);
        step();
        eng_resp_valid = 1'b0;
        eng_resp       = 2'b00;
        if ((rc == 2'b10 || rc == 2'b11) && exp_err != 16'hFFFF) exp_err++;
        chk("err_cnt", 32'(err_cnt), 32'(exp_err));
        last = (exp_idx == NB - 1);
        if (last || !en_at_resp) exp_idx = 0;
        else exp_idx++;
    endtask

    // Called in the FRAME_END cycle; rel_now releases in that same cycle,
    // otherwise hold cycles are spent in HOLD before a release pulse.
    task automatic end_frame(input logic rel_now, input int hold);
        logic swap_now;
        chk("irq_fe", 32'(frame_irq), 1);
        chk("fe_start", 32'(eng_start), 0);
        chk("fe_cnt_old", 32'(frame_cnt), 32'(exp_fc));
        buf_release = rel_now;
        swap_now    = exp_rel || rel_now;
        step();
        buf_release = 1'b0;
        exp_fc = (exp_fc + 1) % 16;
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        chk("irq_after", 32'(frame_irq), 0);
        if (!swap_now) begin
            for (int i = 0; i < hold; i++) begin
                chk("hold_start", 32'(eng_start), 0);
                chk("hold_buf", 32'(wr_buf), 32'(exp_buf));
                chk("hold_busy", 32'(busy), 1);
                step();
            end
            buf_release = 1'b1;
            step();
            buf_release = 1'b0;
        end
        exp_buf = ~exp_buf;
        exp_rel = 1'b0;
        chk("wr_buf", 32'(wr_buf), 32'(exp_buf));
    endtask

    initial begin
        logic [1:0] rc;
        areset = 1'b1; enable = 1'b0; eng_free = 1'b1;
        eng_resp_valid = 1'b0; eng_resp = 2'b00; buf_release = 1'b0;
        #3;
        chk("rst_start", 32'(eng_start), 0);
        chk("rst_addr", eng_addr, 0);
        chk("rst_len", 32'(eng_len), 15);
        chk("rst_buf", 32'(wr_buf), 0);
        chk("rst_fc", 32'(frame_cnt), 0);
        chk("rst_irq", 32'(frame_irq), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        step(); step();
        areset = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 0);

        // Frame 0: plain run, released buffer from reset -> immediate swap.
        enable = 1'b1;
        step();
        for (int b = 0; b < NB; b++) issue_burst(0, 2, 2'b00, 1'b1, 0);
        end_frame(1'b0, 0);

        // Frame 1: engine stall, mixed responses, then HOLD.
        issue_burst(5, 2, 2'b10, 1'b1, 0);
        issue_burst(0, 2, 2'b11, 1'b1, 0);
        issue_burst(0, 2, 2'b00, 1'b1, 0);
        issue_burst(0, 2, 2'b01, 1'b1, 0);
        chk("err_two", 32'(err_cnt), 2);
        end_frame(1'b0, 4);

        // Frame 2: random timing/responses, two early releases absorbed.
        for (int b = 0; b < NB; b++) begin
            rc = 2'($urandom_range(0, 3));
            issue_burst($urandom_range(0, 3), $urandom_range(3, 6), rc, 1'b1, (b == 1) ? 2 : 0);
        end
        end_frame(1'b0, 0);

        // Frame 3: release arrives in the FRAME_END cycle itself.
        for (int b = 0; b < NB; b++) begin
            rc = 2'($urandom_range(0, 3));
            issue_burst($urandom_range(0, 2), $urandom_range(0, 4), rc, 1'b1, 0);
        end
        end_frame(1'b1, 0);

        // Frame 4: drop enable after burst 2, restart at offset 0.
        issue_burst(0, 2, 2'b00, 1'b1, 0);
        issue_burst(0, 2, 2'b00, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            chk("dis_busy", 32'(busy), 0);
            chk("dis_start", 32'(eng_start), 0);
            chk("dis_fc", 32'(frame_cnt), 32'(exp_fc));
            chk("dis_buf", 32'(wr_buf), 32'(exp_buf));
            step();
        end
        enable = 1'b1;
        step();
        for (int b = 0; b < NB; b++) begin
            rc = 2'($urandom_range(0, 3));
            issue_burst($urandom_range(0, 2), $urandom_range(0, 4), rc, 1'b1, 0);
        end
        end_frame(1'b1, 0);

        // Error counter saturation.
        force dut.err_cnt_q = 16'hFFFE;
        #1;
        release dut.err_cnt_q;
        exp_err = 16'hFFFE;
        chk("err_preload", 32'(err_cnt), 32'hFFFE);
        issue_burst(0, 2, 2'b10, 1'b1, 0);
        chk("err_sat1", 32'(err_cnt), 32'hFFFF);
        issue_burst(0, 2, 2'b11, 1'b1, 0);
        chk("err_sat2", 32'(err_cnt), 32'hFFFF);

        // Asynchronous reset while a burst is outstanding.
        eng_free = 1'b1;
        #1;
        chk("pre_rst_start", 32'(eng_start), 1);
        step();
        areset = 1'b1;
        enable = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_err", 32'(err_cnt), 0);
        chk("arst_buf", 32'(wr_buf), 0);
        chk("arst_fc", 32'(frame_cnt), 0);
        chk("arst_start", 32'(eng_start), 0);
        chk("arst_addr", eng_addr, 0);
        step();
        areset = 1'b0;
        step();
        eng_resp_valid = 1'b1;
        eng_resp       = 2'b10;
        step();
        eng_resp_valid = 1'b0;
        eng_resp       = 2'b00;
        step();
        chk("stray_err", 32'(err_cnt), 0);
        chk("stray_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
